rd_dq_delay_trainer: RTL and testbench
======================================

Name: rd_dq_delay_trainer

Overview:
- Fabric-side read-leveling controller for one DDR3 DQ lane input IOD. It is the receive-direction counterpart of the output IODs on the address/command pins.
- Sweeps the IOD dynamic input delay line from tap 0 upward and checks captured RX data against a fixed training pattern at each tap.
- Finds the longest contiguous passing window, then steps the delay line back to the window centre.
- Sits between the PHY training sequencer (START/DONE) and the IOD delay-line port (MOVE/DIRECTION/LOAD/OUT_OF_RANGE).

Parameters:
- TAP_W, 7, width of tap index; sweep covers taps 0..2^TAP_W-1.
- DATA_W, 8, width of RX_DATA_0 per FAB_CLK beat (4:1 DDR gearing).
- PATTERN, 8'h55, expected RX_DATA_0 word on every compare beat.
- SETTLE_CYC, 8, cycles to wait after any LOAD/MOVE before comparing (>=1).
- COMPARE_CYC, 16, beats compared per tap (>=1).

Ports:
- FAB_CLK  input  1  fabric clock; all logic is on its rising edge.
- ARST_N  input  1  asynchronous active-low reset.
- START  input  1  single-cycle request to start training; ignored while BUSY=1.
- RX_DATA_0  input  DATA_W  captured read data from the IOD.
- DELAY_LINE_OUT_OF_RANGE_0  input  1  IOD flag indicating the delay line is at its limit.
- DELAY_LINE_LOAD_0  output  1  one-cycle pulse that reloads the delay line to tap 0.
- DELAY_LINE_MOVE_0  output  1  one-cycle pulse that steps the delay line one tap.
- DELAY_LINE_DIRECTION_0  output  1  1=increment, 0=decrement; valid whenever MOVE=1.
- BUSY  output  1  high from the START acceptance cycle until DONE or ERROR.
- DONE  output  1  one-cycle pulse on successful completion.
- ERROR  output  1  sticky; set when no passing tap is found; cleared by the next accepted START.
- TAP_CENTER  output  TAP_W  final tap; held until the next START.
- WIN_LEN  output  TAP_W+1  length of the best window; held until the next START.

Behaviour:
- Reset: all outputs 0. State = IDLE. All counters and registers 0.
- States: IDLE, LOAD, SETTLE, COMPARE, EVAL, STEP, CENTER, DONE, FAIL.
- IDLE:
  - START=1 -> LOAD.
  - On acceptance: BUSY=1, ERROR=0, cur_tap=0, best_len=0, run_len=0.
- LOAD: assert DELAY_LINE_LOAD_0 for exactly 1 cycle -> SETTLE.
- SETTLE:
  - Count SETTLE_CYC cycles -> COMPARE.
  - No delay-line pulses are issued during SETTLE.
- COMPARE:
  - For COMPARE_CYC consecutive beats, tap_fail |= (RX_DATA_0 != PATTERN).
  - Then -> EVAL.
- EVAL (1 cycle):
  - If OUT_OF_RANGE=1: discard this tap's result, close any open run, -> CENTER.
  - If pass:
    - run_len==0 -> run_start=cur_tap.
    - run_len++.
  - If fail: close run.
  - Closing a run: if run_len > best_len (strictly), then best_start=run_start and best_len=run_len; then run_len=0. Ties keep the earlier window.
  - If cur_tap == 2^TAP_W-1: close run -> CENTER.
  - Otherwise -> STEP.
- STEP:
  - DIRECTION=1 and MOVE=1 for 1 cycle; cur_tap++.
  - -> SETTLE.
- CENTER:
  - If best_len==0 -> FAIL.
  - Otherwise center = best_start + ((best_len-1)>>1), floor.
  - Issue (cur_tap - center) decrement pulses with DIRECTION=0.
  - Each pulse is 1 cycle, followed by 1 idle cycle; cur_tap-- per pulse.
  - When cur_tap==center -> DONE.
  - DIRECTION must be stable in the cycle before and the cycle of each MOVE.
- DONE:
  - DONE=1 for 1 cycle; TAP_CENTER=center; WIN_LEN=best_len; BUSY=0.
  - -> IDLE.
- FAIL:
  - ERROR=1; TAP_CENTER=cur_tap; WIN_LEN=0; BUSY=0.
  - -> IDLE. The delay line is left where the sweep stopped.
- LOAD and MOVE are never asserted in the same cycle. MOVE is never asserted on consecutive cycles.
- START while BUSY=1 has no effect.
- ARST_N low mid-operation: immediate return to the reset values above. The delay line position is then undefined; the sequencer must restart training, which reloads via LOAD.

Test Plan:
- Constant RX_DATA_0=8'h55, START -> 1 LOAD, 127 increment MOVEs, 64 decrement MOVEs; DONE with TAP_CENTER=63, WIN_LEN=128, ERROR=0.
- Pattern correct only at taps 20..40 -> TAP_CENTER=30, WIN_LEN=21; 97 decrement MOVEs after the sweep.
- Passing windows at taps 10..14 and 50..59 -> TAP_CENTER=54, WIN_LEN=10. Equal-length windows 10..14 and 30..34 -> TAP_CENTER=12.
- RX_DATA_0 never matches -> ERROR=1, DONE never pulses, TAP_CENTER=127, WIN_LEN=0, no decrement MOVEs. The next START clears ERROR.
- All taps pass and OUT_OF_RANGE rises while cur_tap=90 -> tap 90 discarded, WIN_LEN=90, TAP_CENTER=44, 46 decrement MOVEs.
- ARST_N pulsed low at tap 40 -> all outputs 0 the same cycle. A second START pulse during the sweep is ignored (exactly one LOAD). A fresh START after reset completes normally.

Source files
------------

// File: rtl/rd_dq_delay_trainer_if.sv
// rtl/rd_dq_delay_trainer_if.sv - sequencer/IOD signal bundle for the read DQ delay trainer
interface rd_dq_delay_trainer_if #(
    parameter int TAP_W  = 7,
    parameter int DATA_W = 8
);
    logic              START;
    logic [DATA_W-1:0] RX_DATA_0;
    logic              DELAY_LINE_OUT_OF_RANGE_0;
    logic              DELAY_LINE_LOAD_0;
    logic              DELAY_LINE_MOVE_0;
    logic              DELAY_LINE_DIRECTION_0;
    logic              BUSY;
    logic              DONE;
    logic              ERROR;
    logic [TAP_W-1:0]  TAP_CENTER;
    logic [TAP_W:0]    WIN_LEN;

    // Environment side: training sequencer plus the IOD.
    modport master (
        output START, RX_DATA_0, DELAY_LINE_OUT_OF_RANGE_0,
        input  DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0,
        input  BUSY, DONE, ERROR, TAP_CENTER, WIN_LEN
    );

    // Trainer side.
    modport slave (
        input  START, RX_DATA_0, DELAY_LINE_OUT_OF_RANGE_0,
        output DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0,
        output BUSY, DONE, ERROR, TAP_CENTER, WIN_LEN
    );
endinterface

// File: rtl/rd_dq_delay_trainer.sv
// rtl/rd_dq_delay_trainer.sv - read-leveling sweep/centre controller for one DQ lane input delay line
module rd_dq_delay_trainer #(
    parameter int                TAP_W       = 7,
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] PATTERN     = 8'h55,
    parameter int                SETTLE_CYC  = 8,
    parameter int                COMPARE_CYC = 16
) (
    input  logic                     FAB_CLK,
    input  logic                     ARST_N,
    rd_dq_delay_trainer_if.slave     bus
);
    localparam int CNT_MAX = (SETTLE_CYC > COMPARE_CYC) ? SETTLE_CYC : COMPARE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CMP_LAST    = CNT_W'(COMPARE_CYC - 1);
    localparam logic [TAP_W-1:0] TAP_LAST    = '1;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_COMPARE, S_EVAL, S_STEP, S_CENTER, S_DONE, S_FAIL
    } state_t;

    state_t           state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             tap_fail_q,   tap_fail_d;
    logic [TAP_W-1:0] cur_tap_q,    cur_tap_d;
    logic [TAP_W:0]   run_len_q,    run_len_d;
    logic [TAP_W-1:0] run_start_q,  run_start_d;
    logic [TAP_W:0]   best_len_q,   best_len_d;
    logic [TAP_W-1:0] best_start_q, best_start_d;
    logic             phase_q,      phase_d;     // CENTER: 0 = idle/decide cycle, 1 = MOVE cycle
    logic             error_q,      error_d;
    logic [TAP_W-1:0] tap_center_q, tap_center_d;
    logic [TAP_W:0]   win_len_q,    win_len_d;

    logic [TAP_W-1:0] center;
    logic [TAP_W:0]   rl;
    logic [TAP_W-1:0] rs;
    logic             close_run;

    // Window centre, rounded down toward the lower tap.
    always_comb begin
        center = TAP_W'({1'b0, best_start_q} + ((best_len_q - (TAP_W+1)'(1)) >> 1));
    end

    // Next-state and datapath updates for the sweep, evaluation and centring.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tap_fail_d   = tap_fail_q;
        cur_tap_d    = cur_tap_q;
        run_len_d    = run_len_q;
        run_start_d  = run_start_q;
        best_len_d   = best_len_q;
        best_start_d = best_start_q;
        phase_d      = phase_q;
        error_d      = error_q;
        tap_center_d = tap_center_q;
        win_len_d    = win_len_q;
        rl           = run_len_q;
        rs           = run_start_q;
        close_run    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    state_d    = S_LOAD;
                    error_d    = 1'b0;
                    cur_tap_d  = '0;
                    run_len_d  = '0;
                    best_len_d = '0;
                end
            end
            S_LOAD: begin
                state_d    = S_SETTLE;
                cnt_d      = '0;
                tap_fail_d = 1'b0;
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_COMPARE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_COMPARE: begin
                tap_fail_d = tap_fail_q | (bus.RX_DATA_0 != PATTERN);
                if (cnt_q == CMP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_EVAL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EVAL: begin
                if (bus.DELAY_LINE_OUT_OF_RANGE_0) begin
                    // The tap at the delay-line limit is not trusted.
                    close_run = 1'b1;
                    state_d   = S_CENTER;
                end else begin
                    if (!tap_fail_q) begin
                        if (rl == '0) rs = cur_tap_q;
                        rl = rl + (TAP_W+1)'(1);
                    end else begin
                        close_run = 1'b1;
                    end
                    if (cur_tap_q == TAP_LAST) begin
                        close_run = 1'b1;
                        state_d   = S_CENTER;
                    end else begin
                        state_d = S_STEP;
                    end
                end
                // Strictly longer wins, so the earliest of equal windows is kept.
                if (close_run) begin
                    if (rl > best_len_q) begin
                        best_len_d   = rl;
                        best_start_d = rs;
                    end
                    rl = '0;
                end
                run_len_d   = rl;
                run_start_d = rs;
                phase_d     = 1'b0;
            end
            S_STEP: begin
                cur_tap_d  = cur_tap_q + TAP_W'(1);
                cnt_d      = '0;
                tap_fail_d = 1'b0;
                state_d    = S_SETTLE;
            end
            S_CENTER: begin
                if (!phase_q) begin
                    if (best_len_q == '0) begin
                        state_d      = S_FAIL;
                        error_d      = 1'b1;
                        tap_center_d = cur_tap_q;
                        win_len_d    = '0;
                    end else if (cur_tap_q == center) begin
                        state_d      = S_DONE;
                        tap_center_d = center;
                        win_len_d    = best_len_q;
                    end else begin
                        phase_d = 1'b1;
                    end
                end else begin
                    cur_tap_d = cur_tap_q - TAP_W'(1);
                    phase_d   = 1'b0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            tap_fail_q   <= 1'b0;
            cur_tap_q    <= '0;
            run_len_q    <= '0;
            run_start_q  <= '0;
            best_len_q   <= '0;
            best_start_q <= '0;
            phase_q      <= 1'b0;
            error_q      <= 1'b0;
            tap_center_q <= '0;
            win_len_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tap_fail_q   <= tap_fail_d;
            cur_tap_q    <= cur_tap_d;
            run_len_q    <= run_len_d;
            run_start_q  <= run_start_d;
            best_len_q   <= best_len_d;
            best_start_q <= best_start_d;
            phase_q      <= phase_d;
            error_q      <= error_d;
            tap_center_q <= tap_center_d;
            win_len_q    <= win_len_d;
        end
    end

    // Outputs decode straight from registers. DIRECTION is 1 in EVAL and STEP so it
    // is settled the cycle before every increment; in CENTER it is 0 throughout.
    assign bus.DELAY_LINE_LOAD_0      = (state_q == S_LOAD);
    assign bus.DELAY_LINE_MOVE_0      = (state_q == S_STEP) || ((state_q == S_CENTER) && phase_q);
    assign bus.DELAY_LINE_DIRECTION_0 = (state_q == S_EVAL) || (state_q == S_STEP);
    assign bus.BUSY                   = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL));
    assign bus.DONE                   = (state_q == S_DONE);
    assign bus.ERROR                  = error_q;
    assign bus.TAP_CENTER             = tap_center_q;
    assign bus.WIN_LEN                = win_len_q;
endmodule

// File: tb/tb_rd_dq_delay_trainer.sv
// tb/tb_rd_dq_delay_trainer.sv - self-checking bench for rd_dq_delay_trainer
module tb_rd_dq_delay_trainer;
    localparam int TAP_W  = 7;
    localparam int DATA_W = 8;
    localparam int NTAP   = 1 << TAP_W;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    rd_dq_delay_trainer_if #(.TAP_W(TAP_W), .DATA_W(DATA_W)) bus();

    rd_dq_delay_trainer #(
        .TAP_W(TAP_W), .DATA_W(DATA_W), .PATTERN(8'h55), .SETTLE_CYC(8), .COMPARE_CYC(16)
    ) dut (
        .FAB_CLK(clk),
        .ARST_N (arst_n),
        .bus    (bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [NTAP-1:0] pass_mask;
    int oor_tap;
    int pos;
    int n_load, n_inc, n_dec, n_done, viol;
    logic prev_move, prev_dir;

    // IOD model: tracks the delay-line tap from LOAD/MOVE pulses and returns read data.
    always @(negedge clk) begin
        if (arst_n) begin
            if (bus.DELAY_LINE_LOAD_0 && bus.DELAY_LINE_MOVE_0) viol++;
            if (bus.DELAY_LINE_MOVE_0 && prev_move) viol++;
            if (bus.DELAY_LINE_MOVE_0 && (prev_dir != bus.DELAY_LINE_DIRECTION_0)) viol++;
            if (bus.DELAY_LINE_LOAD_0) begin
                n_load++;
                pos = 0;
            end
            if (bus.DELAY_LINE_MOVE_0) begin
                if (bus.DELAY_LINE_DIRECTION_0) begin
                    n_inc++;
                    if (pos < NTAP - 1) pos++;
                end else begin
                    n_dec++;
                    if (pos > 0) pos--;
                end
            end
            if (bus.DONE) n_done++;
            prev_move = bus.DELAY_LINE_MOVE_0;
            prev_dir  = bus.DELAY_LINE_DIRECTION_0;
        end
        bus.RX_DATA_0 = pass_mask[pos] ? 8'h55 : (8'h55 ^ 8'($urandom_range(1, 255)));
        bus.DELAY_LINE_OUT_OF_RANGE_0 = (pos >= oor_tap);
    end

    task automatic clear_counts();
        n_load = 0; n_inc = 0; n_dec = 0; n_done = 0; viol = 0;
    endtask

    task automatic set_window(input int lo, input int hi);
        for (int t = lo; t <= hi; t++) pass_mask[t] = 1'b1;
    endtask

    // Reference: longest run of passing taps among those evaluated, earliest on ties.
    task automatic ref_model(input logic [NTAP-1:0] mask, input int oor,
                             output int e_center, output int e_len, output logic e_err,
                             output int e_inc, output int e_dec);
        int stop, last, run, run_s, best, best_s;
        stop = (oor < NTAP) ? oor : NTAP - 1;
        last = (oor < NTAP) ? oor - 1 : NTAP - 1;
        run = 0; run_s = 0; best = 0; best_s = 0;
        for (int t = 0; t <= last; t++) begin
            if (mask[t]) begin
                if (run == 0) run_s = t;
                run++;
                if (run > best) begin
                    best = run;
                    best_s = run_s;
                end
            end else begin
                run = 0;
            end
        end
        e_inc = stop;
        e_len = best;
        e_err = (best == 0);
        if (best == 0) begin
            e_center = stop;
            e_dec = 0;
        end else begin
            e_center = best_s + (best - 1) / 2;
            e_dec = stop - e_center;
        end
    endtask

    task automatic run_and_verify(input string name);
        int e_center, e_len, e_inc, e_dec, cyc, e_pos, e_done;
        logic e_err, seen;
        ref_model(pass_mask, oor_tap, e_center, e_len, e_err, e_inc, e_dec);
        e_pos  = e_err ? e_inc : e_center;
        e_done = e_err ? 0 : 1;
        clear_counts();
        @(negedge clk); bus.START = 1'b1;
        @(negedge clk); bus.START = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.BUSY, bus.ERROR} !== 2'b10) begin
            miscompares++;
            $display("FAIL %s start_busy_err got=%b want=10", name, {bus.BUSY, bus.ERROR});
        end
        seen = 1'b0; cyc = 0;
        while (!seen && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (n_done != 0 || bus.ERROR) seen = 1'b1;
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s completion got=timeout want=done_or_error", name);
        end
        vectors++;
        if (n_done !== e_done) begin
            miscompares++;
            $display("FAIL %s done_pulses got=%0d want=%0d", name, n_done, e_done);
        end
        vectors++;
        if (bus.ERROR !== e_err) begin
            miscompares++;
            $display("FAIL %s error got=%b want=%b", name, bus.ERROR, e_err);
        end
        vectors++;
        if (bus.TAP_CENTER !== 7'(e_center)) begin
            miscompares++;
            $display("FAIL %s tap_center got=%0d want=%0d", name, bus.TAP_CENTER, e_center);
        end
        vectors++;
        if (bus.WIN_LEN !== 8'(e_len)) begin
            miscompares++;
            $display("FAIL %s win_len got=%0d want=%0d", name, bus.WIN_LEN, e_len);
        end
        vectors++;
        if (n_load !== 1) begin
            miscompares++;
            $display("FAIL %s load_pulses got=%0d want=1", name, n_load);
        end
        vectors++;
        if (n_inc !== e_inc) begin
            miscompares++;
            $display("FAIL %s inc_moves got=%0d want=%0d", name, n_inc, e_inc);
        end
        vectors++;
        if (n_dec !== e_dec) begin
            miscompares++;
            $display("FAIL %s dec_moves got=%0d want=%0d", name, n_dec, e_dec);
        end
        vectors++;
        if (pos !== e_pos) begin
            miscompares++;
            $display("FAIL %s final_tap got=%0d want=%0d", name, pos, e_pos);
        end
        vectors++;
        if (viol !== 0) begin
            miscompares++;
            $display("FAIL %s pulse_rules got=%0d violations want=0", name, viol);
        end
        vectors++;
        if (bus.BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_end got=%b want=0", name, bus.BUSY);
        end
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.DELAY_LINE_LOAD_0, bus.DELAY_LINE_MOVE_0, bus.DELAY_LINE_DIRECTION_0, bus.BUSY,
             bus.DONE, bus.ERROR, bus.TAP_CENTER, bus.WIN_LEN} !== 21'd0) begin
            miscompares++;
            $display("FAIL reset outputs got=%h want=0", {bus.DELAY_LINE_LOAD_0, bus.DELAY_LINE_MOVE_0,
                     bus.DELAY_LINE_DIRECTION_0, bus.BUSY, bus.DONE, bus.ERROR, bus.TAP_CENTER, bus.WIN_LEN});
        end
        arst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_all_pass();
        pass_mask = '1; oor_tap = 1000;
        run_and_verify("all_pass");
    endtask

    task automatic test_single_window();
        pass_mask = '0; oor_tap = 1000;
        set_window(20, 40);
        run_and_verify("window_20_40");
    endtask

    task automatic test_two_windows();
        pass_mask = '0; oor_tap = 1000;
        set_window(10, 14); set_window(50, 59);
        run_and_verify("windows_10_50");
    endtask

    task automatic test_tie();
        pass_mask = '0; oor_tap = 1000;
        set_window(10, 14); set_window(30, 34);
        run_and_verify("tie_10_30");
    endtask

    task automatic test_no_pass();
        pass_mask = '0; oor_tap = 1000;
        run_and_verify("no_pass");
    endtask

    task automatic test_error_clear();
        pass_mask = '1; oor_tap = 1000;
        run_and_verify("error_clear");
    endtask

    task automatic test_out_of_range();
        pass_mask = '1; oor_tap = 90;
        run_and_verify("oor_90");
    endtask

    task automatic test_async_reset();
        int cyc;
        logic regs_zero;
        pass_mask = '1; oor_tap = 1000;
        clear_counts();
        @(negedge clk); bus.START = 1'b1;
        @(negedge clk); bus.START = 1'b0;
        cyc = 0;
        while (pos != 10 && cyc < 5000) begin @(negedge clk); cyc++; end
        bus.START = 1'b1;
        @(negedge clk); bus.START = 1'b0;
        while (pos != 40 && cyc < 5000) begin @(negedge clk); cyc++; end
        vectors++;
        if (pos != 40) begin
            miscompares++;
            $display("FAIL async_reset reach_tap40 got=%0d want=40", pos);
        end
        vectors++;
        if (n_load !== 1) begin
            miscompares++;
            $display("FAIL async_reset second_start_loads got=%0d want=1", n_load);
        end
        #2 arst_n = 1'b0;
        #1;
        regs_zero = ({bus.DELAY_LINE_LOAD_0, bus.DELAY_LINE_MOVE_0, bus.DELAY_LINE_DIRECTION_0, bus.BUSY,
                      bus.DONE, bus.ERROR, bus.TAP_CENTER, bus.WIN_LEN} === 21'd0);
        vectors++;
        if (!regs_zero) begin
            miscompares++;
            $display("FAIL async_reset outputs got=busy%b tc%0d wl%0d want=all_zero",
                     bus.BUSY, bus.TAP_CENTER, bus.WIN_LEN);
        end
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_and_verify("after_reset");
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int nwin, lo, len;
            pass_mask = '0;
            nwin = $urandom_range(1, 3);
            for (int w = 0; w < nwin; w++) begin
                lo  = $urandom_range(0, NTAP - 2);
                len = $urandom_range(1, 30);
                set_window(lo, (lo + len - 1 > NTAP - 1) ? NTAP - 1 : lo + len - 1);
            end
            oor_tap = ($urandom_range(0, 3) == 0) ? $urandom_range(40, NTAP - 2) : 1000;
            run_and_verify($sformatf("random_%0d", r));
        end
    endtask

    initial begin
        bus.START = 1'b0;
        bus.RX_DATA_0 = '0;
        bus.DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
        pass_mask = '1;
        oor_tap = 1000;
        pos = 0;
        prev_move = 1'b0;
        prev_dir = 1'b0;
        clear_counts();
        test_reset();
        test_all_pass();
        test_single_window();
        test_two_windows();
        test_tie();
        test_no_pass();
        test_error_clear();
        test_out_of_range();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
